// File: rtl/osc_bank_sampler_if.sv
// rtl/osc_bank_sampler_if.sv - host control and readout bundle for osc_bank_sampler
interface osc_bank_sampler_if #(
  parameter int CHANNELS   = 16,
  parameter int CNT_W      = 16,
  parameter int SUM_W      = 16,
  parameter int DEPTH_LOG2 = 14,
  parameter int WIN_W      = 16
) ();
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                  START;
  logic                  MODE;
  logic [SEL_W-1:0]      CH_SEL;
  logic [WIN_W-1:0]      WINDOW_LEN;
  logic [DEPTH_LOG2:0]   N_SAMPLES;
  logic                  BUSY;
  logic                  DONE;
  logic                  OVF;
  logic                  RD_EN;
  logic [DEPTH_LOG2-1:0] RD_ADDR;
  logic [SUM_W-1:0]      RD_DATA;
  logic                  RD_VALID;

  modport master (
    output START, MODE, CH_SEL, WINDOW_LEN, N_SAMPLES, RD_EN, RD_ADDR,
    input  BUSY, DONE, OVF, RD_DATA, RD_VALID
  );

  modport slave (
    input  START, MODE, CH_SEL, WINDOW_LEN, N_SAMPLES, RD_EN, RD_ADDR,
    output BUSY, DONE, OVF, RD_DATA, RD_VALID
  );
endinterface

// File: rtl/osc_bank_sampler.sv
// rtl/osc_bank_sampler.sv - windowed oscillator bank sampler with result RAM; OSC_BANK_SATURATE_EN selects saturating results
module osc_bank_sampler #(
  parameter int CHANNELS   = 16,
  parameter int CNT_W      = 16,
  parameter int SUM_W      = 16,
  parameter int DEPTH_LOG2 = 14,
  parameter int WIN_W      = 16
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic [CHANNELS*CNT_W-1:0] OSC_COUNT,
  output logic                      CNT_CLEAR,
  osc_bank_sampler_if.slave         bus
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ACC_W = SUM_W + CNT_W;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [SEL_W:0]   CH_LIM   = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, COUNT, SNAP, ACC, WRITE} state_t;

  state_t                    state, state_d;
  logic                      mode_r;
  logic [SEL_W-1:0]          sel_r;
  logic [WIN_W-1:0]          win_r;
  logic [DEPTH_LOG2:0]       nsamp_r;
  logic [DEPTH_LOG2:0]       wr_ptr;
  logic [WIN_W-1:0]          win_cnt;
  logic [WIN_W-1:0]          win_end;
  logic [SEL_W-1:0]          ch_idx;
  logic [CHANNELS*CNT_W-1:0] snap;
  logic [ACC_W-1:0]          acc;
  logic                      done_r;
  logic                      ovf_r;
  logic                      win_last;
  logic                      acc_last;
  logic                      wr_last;
  logic                      sel_ok;
  logic [SUM_W-1:0]          result;
  logic                      res_ovf;
  logic                      rd_ok;
  logic                      rd_valid_r;
  logic [SUM_W-1:0]          rd_data_r;
  logic [SUM_W-1:0]          ram [DEPTH];

  // Window, channel and pointer terminal conditions; a zero window behaves as one cycle
  always_comb begin
    win_end  = (win_r == '0) ? '0 : win_r - 1'b1;
    win_last = (win_cnt == win_end);
    acc_last = mode_r || (ch_idx == LAST_IDX);
    wr_last  = ((wr_ptr + 1'b1) == nsamp_r);
    sel_ok   = ({1'b0, sel_r} < CH_LIM);
    rd_ok    = bus.RD_EN && (state == IDLE);
  end

  // Reduce the wide accumulator to the stored word width
  always_comb begin
`ifdef OSC_BANK_SATURATE_EN
    res_ovf = |acc[ACC_W-1:SUM_W];
    result  = res_ovf ? '1 : acc[SUM_W-1:0];
`else
    res_ovf = 1'b0;
    result  = acc[SUM_W-1:0];
`endif
  end

  // State register
  always_ff @(posedge CLOCK) begin
    if (!RESET) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and state-decoded outputs; counters are held clear outside the count window
  always_comb begin
    state_d   = state;
    CNT_CLEAR = 1'b1;
    bus.BUSY  = (state != IDLE);
    case (state)
      IDLE:    if (bus.START && (bus.N_SAMPLES != '0)) state_d = CLEAR;
      CLEAR:   state_d = COUNT;
      COUNT: begin
        CNT_CLEAR = 1'b0;
        if (win_last) state_d = SNAP;
      end
      SNAP:    state_d = ACC;
      ACC:     if (acc_last) state_d = WRITE;
      WRITE:   state_d = wr_last ? IDLE : CLEAR;
      default: state_d = IDLE;
    endcase
  end

  // Capture parameters, window timing, snapshot, accumulation and sticky status
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      mode_r  <= 1'b0;
      sel_r   <= '0;
      win_r   <= '0;
      nsamp_r <= '0;
      wr_ptr  <= '0;
      win_cnt <= '0;
      ch_idx  <= '0;
      snap    <= '0;
      acc     <= '0;
      done_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.START) begin
            mode_r  <= bus.MODE;
            sel_r   <= bus.CH_SEL;
            win_r   <= bus.WINDOW_LEN;
            nsamp_r <= bus.N_SAMPLES;
            wr_ptr  <= '0;
            ovf_r   <= 1'b0;
            done_r  <= (bus.N_SAMPLES == '0);
          end
        end
        CLEAR: win_cnt <= '0;
        COUNT: win_cnt <= win_cnt + 1'b1;
        SNAP: begin
          snap   <= OSC_COUNT;
          acc    <= '0;
          ch_idx <= '0;
        end
        ACC: begin
          if (mode_r)
            acc <= sel_ok ? ACC_W'(snap[sel_r*CNT_W +: CNT_W]) : '0;
          else
            acc <= acc + ACC_W'(snap[ch_idx*CNT_W +: CNT_W]);
          ch_idx <= ch_idx + 1'b1;
        end
        WRITE: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (wr_last) done_r <= 1'b1;
          if (res_ovf) ovf_r  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result RAM write port; contents survive reset
  always_ff @(posedge CLOCK) begin
    if (state == WRITE) ram[wr_ptr[DEPTH_LOG2-1:0]] <= result;
  end

  // Registered read port, only serviced while idle
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
    end else begin
      rd_valid_r <= rd_ok;
      if (rd_ok) rd_data_r <= ram[bus.RD_ADDR];
    end
  end

  assign bus.DONE     = done_r;
  assign bus.OVF      = ovf_r;
  assign bus.RD_VALID = rd_valid_r;
  assign bus.RD_DATA  = rd_data_r;
endmodule
